adc16_reader: RTL and testbench

ADC16_READER -- requirements
Module: adc16_reader

---
 rtl/adc16_reader.sv | 166 ++++++++++++++++
 tb/tb_adc16_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc16_reader.sv
// Serial reader for a 16-bit ADC: frames CS_N/SCLK, shifts DOUT MSB first, presents the last 16 bits.
// Define ADC16_READER_STATUS_EN to also capture the 8 header bits preceding the data word on STATUS.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | CS_N high, waiting for START
// S_SETUP  | CS_N low, SCLK low for HALF cycles before the first rise
// S_SCK_HI | SCLK high phase; DOUT captured as the phase ends
// S_SCK_LO | SCLK low phase between bits
// S_HOLD   | SCLK low after the last bit, before CS_N rises
// S_DONE   | VALID strobe cycle; BUSY drops on exit
module adc16_reader #(
    parameter int HALF       = 5,
    parameter int FRAME_BITS = 24
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        DOUT,
    output logic        CS_N,
    output logic        SCLK,
    output logic [15:0] DATA16,
    output logic        VALID,
    output logic        BUSY,
    output logic [7:0]  STATUS
);

    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
    localparam logic [5:0] FB_L    = 6'(FRAME_BITS);
`ifdef ADC16_READER_STATUS_EN
    localparam int SR_W = 24;
`else
    localparam int SR_W = 16;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        dly_q, dly_d;
    logic [5:0]        bit_q, bit_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              dly_last;
    logic [5:0]        bit_inc;

    assign dly_last = (dly_q == 8'd0);
    assign bit_inc  = bit_q + 6'd1;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sr_d    = '0;
                    bit_d   = '0;
                    dly_d   = HALF_M1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_SCK_LO: begin
                if (dly_last) begin
                    sclk_d  = 1'b1;
                    dly_d   = HALF_M1;
                    state_d = S_SCK_HI;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            S_SCK_HI: begin
                if (dly_last) begin
                    // DOUT is stable here: the converter only moves it on SCLK falling edges
                    sr_d    = {sr_q[SR_W-2:0], DOUT};
                    sclk_d  = 1'b0;
                    bit_d   = bit_inc;
                    dly_d   = HALF_M1;
                    state_d = (bit_inc < FB_L) ? S_SCK_LO : S_HOLD;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (dly_last) begin
                    cs_n_d  = 1'b1;
                    data_d  = sr_q[15:0];
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ADC16_READER_STATUS_EN
    logic [7:0] status_q, status_d;

    always_comb begin
        status_d = status_q;
        if (state_q == S_HOLD && dly_last) begin
            status_d = sr_q[23:16];
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) status_q <= '0;
        else          status_q <= status_d;
    end

    assign STATUS = status_q;
`else
    assign STATUS = 8'h00;
`endif

    assign CS_N   = cs_n_q;
    assign SCLK   = sclk_q;
    assign DATA16 = data_q;
    assign VALID  = valid_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_adc16_reader.sv
// Directed bench for adc16_reader: three instances (5/24, 2/24, 255/16) with a converter model per instance.
module tb_adc16_reader;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] cs_v, sclk_v, valid_v, busy_v;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ADC16_READER_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int H  = (g == 0) ? 5 : (g == 1) ? 2 : 255;
        localparam int FB = (g == 2) ? 16 : 24;

        logic        dout = 1'b0;
        logic [15:0] data16;
        logic [7:0]  status;
        logic [31:0] stream = '0;
        int cs_len = 0, last_cs_len = 0, rises = 0, last_rises = 0, fall_cnt = 0;
        int frames = 0, gap = 0, last_gap = 0, valid_cnt = 0, busy_gaps = 0;
        logic cs_prev = 1'b1, sclk_prev = 1'b0;

        adc16_reader #(.HALF(H), .FRAME_BITS(FB)) dut (
            .CLK_50 (clk),
            .RESET_N(rst_n),
            .START  (start_v[g]),
            .DOUT   (dout),
            .CS_N   (cs_v[g]),
            .SCLK   (sclk_v[g]),
            .DATA16 (data16),
            .VALID  (valid_v[g]),
            .BUSY   (busy_v[g]),
            .STATUS (status)
        );

        // converter model and frame monitor; DOUT moves only after SCLK has fallen
        always @(negedge clk) begin
            if (!cs_v[g]) begin
                if (cs_prev) begin
                    rises = 0; fall_cnt = 0; cs_len = 0; frames++;
                    last_gap = gap; gap = 0;
                end
                cs_len++;
                if (sclk_v[g] && !sclk_prev) rises++;
                if (!sclk_v[g] && sclk_prev) fall_cnt++;
                dout = (fall_cnt < FB) ? stream[FB-1-fall_cnt] : 1'b0;
                if (busy_v[g] !== 1'b1) busy_gaps++;
            end else begin
                if (!cs_prev) begin
                    last_cs_len = cs_len;
                    last_rises  = rises;
                end
                gap++;
            end
            if (valid_v[g]) valid_cnt++;
            cs_prev   = cs_v[g];
            sclk_prev = sclk_v[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int g, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid_v[g]) seen = 1'b1;
        end
        chk({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int  v0, f0, bg0, n;
        bit  hit;

        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n",   {29'd0, cs_v},   32'h7);
        chk("rst_sclk",   {29'd0, sclk_v}, 32'h0);
        chk("rst_valid",  {29'd0, valid_v}, 32'h0);
        chk("rst_busy",   {29'd0, busy_v}, 32'h0);
        chk("rst_data16", {16'd0, u[0].data16}, 32'h0);
        chk("rst_status", {24'd0, u[0].status}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic frame, HALF=5 FRAME_BITS=24
        u[0].stream = 32'h00A51234;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("t1_cs_low",  {31'd0, cs_v[0]}, 32'h0);
        chk("t1_busy_on", {31'd0, busy_v[0]}, 32'h1);
        wait_valid(0, 400, "t1");
        chk("t1_data16", {16'd0, u[0].data16}, 32'h1234);
        chk("t1_status", {24'd0, u[0].status}, ST_EN ? 32'hA5 : 32'h00);
        chk("t1_busy_at_valid", {31'd0, busy_v[0]}, 32'h1);
        chk("t1_cs_high_at_valid", {31'd0, cs_v[0]}, 32'h1);
        @(negedge clk);
        chk("t1_valid_drop", {31'd0, valid_v[0]}, 32'h0);
        chk("t1_busy_drop",  {31'd0, busy_v[0]}, 32'h0);
        chk("t1_cs_low_len", u[0].last_cs_len, 32'd245);
        chk("t1_sclk_rises", u[0].last_rises, 32'd24);
        chk("t1_valid_cnt",  u[0].valid_cnt, 32'd1);
        repeat (5) @(negedge clk);
        chk("t1_data_hold",  {16'd0, u[0].data16}, 32'h1234);

        // reset at the 12th SCLK rise, then restart right after release
        u[0].stream = 32'h003C9E71;
        v0 = u[0].valid_cnt;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (u[0].rises == 12) hit = 1'b1;
        end
        chk("rst_mid_reached_rise12", {31'd0, hit}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs_n",   {31'd0, cs_v[0]}, 32'h1);
        chk("rst_mid_sclk",   {31'd0, sclk_v[0]}, 32'h0);
        chk("rst_mid_busy",   {31'd0, busy_v[0]}, 32'h0);
        chk("rst_mid_data16", {16'd0, u[0].data16}, 32'h0);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_valid", u[0].valid_cnt, v0);
        rst_n = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("rst_rel_first_start_cs", {31'd0, cs_v[0]}, 32'h0);
        chk("rst_rel_first_start_busy", {31'd0, busy_v[0]}, 32'h1);
        wait_valid(0, 400, "rst_rel");
        chk("rst_rel_data16", {16'd0, u[0].data16}, 32'h9E71);
        chk("rst_rel_status", {24'd0, u[0].status}, ST_EN ? 32'h3C : 32'h00);
        @(negedge clk);
        chk("rst_rel_cs_low_len", u[0].last_cs_len, 32'd245);
        chk("rst_rel_sclk_rises", u[0].last_rises, 32'd24);

        // extra START pulses mid-frame are ignored
        u[0].stream = 32'h0012ABCD;
        v0  = u[0].valid_cnt;
        f0  = u[0].frames;
        bg0 = u[0].busy_gaps;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("t2_busy_c20", {31'd0, busy_v[0]}, 32'h1);
        repeat (79) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("t2_data_unchanged_midframe", {16'd0, u[0].data16}, 32'h9E71);
        wait_valid(0, 300, "t2");
        chk("t2_data16", {16'd0, u[0].data16}, 32'hABCD);
        repeat (20) @(negedge clk);
        n = u[0].frames - f0;
        chk("t2_one_frame", n, 32'd1);
        n = u[0].valid_cnt - v0;
        chk("t2_one_valid", n, 32'd1);
        n = u[0].busy_gaps - bg0;
        chk("t2_busy_continuous", n, 32'd0);
        chk("t2_idle_cs_n", {31'd0, cs_v[0]}, 32'h1);

        // back-to-back frames with START held, HALF=2
        u[1].stream = 32'h00FFFFFF;
        start_v[1] = 1'b1;
        wait_valid(1, 200, "t3a");
        chk("t3_data_ffff", {16'd0, u[1].data16}, 32'hFFFF);
        u[1].stream = 32'h00000000;
        wait_valid(1, 200, "t3b");
        start_v[1] = 1'b0;
        chk("t3_data_0000", {16'd0, u[1].data16}, 32'h0000);
        chk("t3_cs_gap", u[1].last_gap, 32'd2);
        @(negedge clk);
        chk("t3_cs_low_len", u[1].last_cs_len, 32'd98);
        chk("t3_sclk_rises", u[1].last_rises, 32'd24);
        repeat (10) @(negedge clk);
        chk("t3_stopped", {31'd0, cs_v[1]}, 32'h1);

        // shortest frame with the longest half-period
        u[2].stream = 32'h00008001;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        wait_valid(2, 9000, "t4");
        chk("t4_data16", {16'd0, u[2].data16}, 32'h8001);
        chk("t4_status", {24'd0, u[2].status}, 32'h00);
        @(negedge clk);
        chk("t4_cs_low_len", u[2].last_cs_len, 32'd8415);
        chk("t4_sclk_rises", u[2].last_rises, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
